// File: rtl/motor_cmd_pkg.sv
// Shared definitions for the host-link command sequencer: FSM state encoding,
// frame constants, the register-write payload and the frame checksum helper.
package motor_cmd_pkg;

   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
   localparam int unsigned FRAME_LEN     = 6;
   localparam int unsigned ADDR_W        = 16;
   localparam int unsigned DATA_W        = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_H,
      S_ADDR_L,
      S_DATA_H,
      S_DATA_L,
      S_CHK,
      S_ISSUE,
      S_GAP
   } state_e;

   // One register write as carried from the frame to the controller bus.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } reg_wr_t;

   // Frame checksum: XOR of the four payload bytes, sync byte excluded.
   function automatic logic [7:0] frame_chk(input logic [7:0] a_h,
                                            input logic [7:0] a_l,
                                            input logic [7:0] d_h,
                                            input logic [7:0] d_l);
      return a_h ^ a_l ^ d_h ^ d_l;
   endfunction

endpackage

// File: rtl/motor_cmd_timeout.sv
// Inter-byte watchdog for host-link stages.
// Up-counter that advances while en_i is high and is zeroed by clr_i; it wraps
// after LIMIT cycles. expire_o is registered and is high for exactly the cycle
// in which the count sits at LIMIT-1, so a consumer that sees expire_o without
// any other activity that cycle knows LIMIT cycles have elapsed.
// Ports:
//   hclk      clock, rising edge
//   rst       asynchronous active-high reset
//   clr_i     synchronous clear (dominates en_i)
//   en_i      count enable
//   expire_o  high while the count equals LIMIT-1
module motor_cmd_timeout #(
   parameter int unsigned LIMIT = 50000
) (
   input  logic hclk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire_q, expire_d;

   // Next count; expire is derived from the next count so it stays registered.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      expire_d = (cnt_d == LAST);
   end

   always_ff @(posedge hclk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_d;
      end
   end

   assign expire_o = expire_q;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// Host byte stream to controller register-write sequencer.
// Collects SYNC/ADDR_H/ADDR_L/DATA_H/DATA_L/CHK frames from a valid/ready byte
// input, validates checksum and address range, and issues one-cycle register
// writes followed by a guaranteed idle gap with rxReady low.
// Optional build macro: MOTOR_CMD_ERRCNT_EN adds the errCount port
// (saturating count of aborted frames, cleared only by rst).
// Ports:
//   hclk      clock, rising edge
//   rst       asynchronous active-high reset
//   rxData    received byte
//   rxValid   rxData valid
//   rxReady   byte accepted this cycle when rxValid is also high
//   address   register index to controller (holds until next good frame)
//   wrData    register value to controller (holds until next good frame)
//   wr        one-cycle write strobe
//   frameErr  one-cycle pulse on any aborted frame
//   busy      high in every state except idle
//   errCount  (MOTOR_CMD_ERRCNT_EN only) saturating aborted-frame count
module motor_cmd_sequencer
   import motor_cmd_pkg::*;
#(
   parameter logic [7:0]        SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned       TIMEOUT_CYCLES = 50000,
   parameter int unsigned       MIN_WR_GAP     = 4,
   parameter logic [ADDR_W-1:0] ADDR_LIMIT     = 16'h0100
) (
   input  logic              hclk,
   input  logic              rst,
   input  logic [7:0]        rxData,
   input  logic              rxValid,
   output logic              rxReady,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] wrData,
   output logic              wr,
   output logic              frameErr,
   output logic              busy
`ifdef MOTOR_CMD_ERRCNT_EN
   ,
   output logic [7:0]        errCount
`endif
);

   localparam int unsigned GAP_W = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;

   state_e            state_q, state_d;
   reg_wr_t           shadow_q, shadow_d;
   reg_wr_t           out_q, out_d;
   logic [7:0]        chk_q, chk_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              wr_q, wr_d;
   logic              frame_err_q, frame_err_d;
   logic              rx_ready_q, rx_ready_d;
   logic              busy_q, busy_d;

   logic              accept;
   logic              in_frame;
   logic              expire;

   assign accept   = rxValid && rx_ready_q;
   assign in_frame = (state_q == S_ADDR_H) || (state_q == S_ADDR_L) ||
                     (state_q == S_DATA_H) || (state_q == S_DATA_L) ||
                     (state_q == S_CHK);

   // Inter-byte watchdog: only runs while a frame is open; any accepted byte
   // restarts it, so a byte on the expiring edge takes priority.
   motor_cmd_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .hclk     (hclk),
      .rst      (rst),
      .clr_i    (accept || !in_frame),
      .en_i     (in_frame),
      .expire_o (expire)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      shadow_d    = shadow_q;
      out_d       = out_q;
      chk_d       = chk_q;
      gap_d       = gap_q;
      wr_d        = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Non-sync bytes are dropped without complaint.
            if (accept && (rxData == SYNC_BYTE)) begin
               state_d = S_ADDR_H;
               chk_d   = '0;
            end
         end
         S_ADDR_H: begin
            if (accept) begin
               shadow_d.addr[15:8] = rxData;
               chk_d               = chk_q ^ rxData;
               state_d             = S_ADDR_L;
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end
         end
         S_ADDR_L: begin
            if (accept) begin
               shadow_d.addr[7:0] = rxData;
               chk_d              = chk_q ^ rxData;
               state_d            = S_DATA_H;
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end
         end
         S_DATA_H: begin
            if (accept) begin
               shadow_d.data[15:8] = rxData;
               chk_d               = chk_q ^ rxData;
               state_d             = S_DATA_L;
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end
         end
         S_DATA_L: begin
            if (accept) begin
               shadow_d.data[7:0] = rxData;
               chk_d              = chk_q ^ rxData;
               state_d            = S_CHK;
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end
         end
         S_CHK: begin
            if (accept) begin
               if ((rxData == chk_q) && (shadow_q.addr < ADDR_LIMIT)) begin
                  // Bus outputs and strobe launch together on the CHK edge.
                  state_d = S_ISSUE;
                  out_d   = shadow_q;
                  wr_d    = 1'b1;
               end else begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
               end
            end else if (expire) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end
         end
         S_ISSUE: begin
            state_d = S_GAP;
            gap_d   = GAP_W'(MIN_WR_GAP - 1);
         end
         S_GAP: begin
            if (gap_q == '0) begin
               state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered status follows the state being entered.
      rx_ready_d = (state_d != S_ISSUE) && (state_d != S_GAP);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge hclk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shadow_q    <= '0;
         out_q       <= '0;
         chk_q       <= '0;
         gap_q       <= '0;
         wr_q        <= 1'b0;
         frame_err_q <= 1'b0;
         rx_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         out_q       <= out_d;
         chk_q       <= chk_d;
         gap_q       <= gap_d;
         wr_q        <= wr_d;
         frame_err_q <= frame_err_d;
         rx_ready_q  <= rx_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign rxReady  = rx_ready_q;
   assign address  = out_q.addr;
   assign wrData   = out_q.data;
   assign wr       = wr_q;
   assign frameErr = frame_err_q;
   assign busy     = busy_q;

`ifdef MOTOR_CMD_ERRCNT_EN
   logic [7:0] err_cnt_q;

   // Saturating count, updated on the same edge that raises frameErr.
   always_ff @(posedge hclk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (frame_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign errCount = err_cnt_q;
`endif

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed frame table plus hand sequences for
// timeout, reset mid-frame and (with MOTOR_CMD_ERRCNT_EN) error-count saturation.
module tb_motor_cmd_sequencer;
   import motor_cmd_pkg::*;

   localparam int unsigned TO  = 20;
   localparam int unsigned GAP = 4;
   localparam int unsigned NV  = 6;

   logic        hclk = 1'b0;
   logic        rst  = 1'b1;
   logic [7:0]  rxData = 8'h00;
   logic        rxValid = 1'b0;
   logic        rxReady;
   logic [15:0] address;
   logic [15:0] wrData;
   logic        wr;
   logic        frameErr;
   logic        busy;
`ifdef MOTOR_CMD_ERRCNT_EN
   logic [7:0]  errCount;
`endif

   motor_cmd_sequencer #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TO),
      .MIN_WR_GAP     (GAP),
      .ADDR_LIMIT     (16'h0100)
   ) dut (
      .hclk     (hclk),
      .rst      (rst),
      .rxData   (rxData),
      .rxValid  (rxValid),
      .rxReady  (rxReady),
      .address  (address),
      .wrData   (wrData),
      .wr       (wr),
      .frameErr (frameErr),
      .busy     (busy)
`ifdef MOTOR_CMD_ERRCNT_EN
      ,
      .errCount (errCount)
`endif
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic [71:0] b;     // bytes left-aligned, first byte in bits 71:64
      int          n;
      logic        wr;
      logic        err;
      logic [15:0] addr;
      logic [15:0] data;
   } vec_t;

   vec_t vecs [NV];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   // Present one byte and hold it until the edge that accepts it.
   task automatic send(input logic [7:0] b);
      int w;
      w = 0;
      rxData  = b;
      rxValid = 1'b1;
      while (!rxReady && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) check("ready_wait", 32'(rxReady), 32'd1);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      logic stray;
      logic busy_low;
`ifdef MOTOR_CMD_ERRCNT_EN
      int exp_errcnt = 0;
`endif

      vecs[0] = '{72'hA5_00_12_34_56_70_000000, 6, 1'b1, 1'b0, 16'h0012, 16'h3456};
      vecs[1] = '{72'hA5_00_12_34_56_71_000000, 6, 1'b0, 1'b1, 16'h0012, 16'h3456};
      vecs[2] = '{72'h00_FF_13_A5_00_34_12_AB_8D, 9, 1'b1, 1'b0, 16'h0034, 16'h12AB};
      vecs[3] = '{72'hA5_01_00_12_34_27_000000, 6, 1'b0, 1'b1, 16'h0034, 16'h12AB};
      vecs[4] = '{72'hA5_00_FF_BE_EF_AE_000000, 6, 1'b1, 1'b0, 16'h00FF, 16'hBEEF};
      vecs[5] = '{72'hA5_00_A5_A5_00_00_000000, 6, 1'b1, 1'b0, 16'h00A5, 16'hA500};

      // Reset state.
      tick();
      tick();
      check("rst_rxReady", 32'(rxReady), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wr_err", 32'({wr, frameErr}), 32'd0);
      check("rst_address", 32'(address), 32'd0);
      check("rst_wrData", 32'(wrData), 32'd0);
      rst = 1'b0;
      tick();

      // Frame table.
      for (int i = 0; i < NV; i++) begin
         stray = 1'b0;
         for (int k = 0; k < vecs[i].n; k++) begin
            send(vecs[i].b[71 - 8*k -: 8]);
            if (k < vecs[i].n - 1 && (frameErr || wr)) stray = 1'b1;
         end
         rxValid = 1'b0;
         check($sformatf("v%0d_wr", i), 32'(wr), 32'(vecs[i].wr));
         check($sformatf("v%0d_frameErr", i), 32'(frameErr), 32'(vecs[i].err));
         check($sformatf("v%0d_address", i), 32'(address), 32'(vecs[i].addr));
         check($sformatf("v%0d_wrData", i), 32'(wrData), 32'(vecs[i].data));
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].wr));
         check($sformatf("v%0d_stray", i), 32'(stray), 32'd0);
`ifdef MOTOR_CMD_ERRCNT_EN
         if (vecs[i].err) exp_errcnt++;
         check($sformatf("v%0d_errCount", i), 32'(errCount), 32'(exp_errcnt));
`endif
         tick();
         check($sformatf("v%0d_pulse_end", i), 32'({wr, frameErr}), 32'd0);
         lows = 0;
         while (!rxReady && lows < 20) begin
            lows++;
            tick();
         end
         check($sformatf("v%0d_gap", i), 32'(lows), vecs[i].wr ? 32'(GAP) : 32'd0);
      end

      // Timeout: frame stalls after ADDR_L.
      send(8'hA5); send(8'h00); send(8'h12);
      rxValid  = 1'b0;
      stray    = 1'b0;
      busy_low = 1'b0;
      repeat (TO - 1) begin
         tick();
         if (frameErr) stray = 1'b1;
         if (!busy) busy_low = 1'b1;
      end
      check("to_early_err", 32'(stray), 32'd0);
      check("to_busy_held", 32'(busy_low), 32'd0);
      tick();
      check("to_frameErr", 32'(frameErr), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_rxReady", 32'(rxReady), 32'd1);
`ifdef MOTOR_CMD_ERRCNT_EN
      exp_errcnt++;
      check("to_errCount", 32'(errCount), 32'(exp_errcnt));
`endif
      tick();
      check("to_pulse_end", 32'(frameErr), 32'd0);

      // Byte arriving on the expiring edge keeps the frame alive.
      send(8'hA5); send(8'h00); send(8'h12);
      rxValid = 1'b0;
      repeat (TO - 1) tick();
      send(8'h34);
      check("late_no_err", 32'(frameErr), 32'd0);
      check("late_busy", 32'(busy), 32'd1);
      send(8'h56); send(8'h70);
      rxValid = 1'b0;
      check("late_wr", 32'(wr), 32'd1);
      check("late_address", 32'(address), 32'h0012);
      check("late_wrData", 32'(wrData), 32'h3456);
      repeat (GAP + 2) tick();

      // Reset in S_DATA_L.
      send(8'hA5); send(8'h00); send(8'h12); send(8'h34);
      rxValid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mrst_outputs", 32'({wr, frameErr, busy, rxReady}), 32'b0001);
      check("mrst_address", 32'(address), 32'd0);
      check("mrst_wrData", 32'(wrData), 32'd0);
`ifdef MOTOR_CMD_ERRCNT_EN
      check("mrst_errCount", 32'(errCount), 32'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
      stray = 1'b0;
      send(8'h56);
      if (wr || frameErr) stray = 1'b1;
      send(8'h70);
      if (wr || frameErr) stray = 1'b1;
      rxValid = 1'b0;
      tick();
      if (wr || frameErr) stray = 1'b1;
      check("mrst_no_partial", 32'(stray), 32'd0);
      send(8'hA5); send(8'h00); send(8'h42); send(8'h56); send(8'h78); send(8'h6C);
      rxValid = 1'b0;
      check("mrst_wr", 32'(wr), 32'd1);
      check("mrst_new_address", 32'(address), 32'h0042);
      check("mrst_new_wrData", 32'(wrData), 32'h5678);
      repeat (GAP + 2) tick();

`ifdef MOTOR_CMD_ERRCNT_EN
      // Saturation: 300 bad-checksum frames.
      for (int f = 0; f < 300; f++) begin
         send(8'hA5); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
         send(frame_chk(8'h00, 8'h00, 8'h00, 8'h00) ^ 8'h01);
      end
      rxValid = 1'b0;
      tick();
      check("errCount_sat", 32'(errCount), 32'hFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
